cdc_data_launch: RTL

Source-side launcher for the multi-bit enable-qualified CDC path. It accepts words from a valid/ready stream in the `clk_a` domain and drives `data_in`/`data_en` toward the capture block. It holds each word stable under a four-phase request/acknowledge handshake, with the acknowledge returned from the `clk_b` domain. It guarantees data is stable before `data_en` rises and until the far side has captured it, with a minimum enable width and an optional acknowledge timeout.

---
 rtl/cdc_pkg.sv | 14 +
 rtl/bit_sync.sv | 25 ++
 rtl/cdc_data_launch.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// Shared types and default constants for the enable-qualified CDC launch/capture pair.
package cdc_pkg;

  localparam int unsigned CDC_SYNC_STAGES = 2;
  localparam int unsigned CDC_DATA_W      = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAssert,
    StRelease
  } launch_state_t;

endpackage

// File: rtl/bit_sync.sv
// N-stage single-bit synchroniser with synchronous active-low reset.
module bit_sync
  import cdc_pkg::*;
#(
  parameter int unsigned N = CDC_SYNC_STAGES
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d};
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/cdc_data_launch.sv
// Source-side launcher: holds each accepted word under a four-phase data_en/ack handshake
// with a minimum enable width and an optional acknowledge timeout.
module cdc_data_launch
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_W      = CDC_DATA_W,
  parameter int unsigned HOLD_MIN    = 4,
  parameter int unsigned SYNC_STAGES = CDC_SYNC_STAGES,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic              clk_a,
  input  logic              arstn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_in,
  output logic              data_en,
  input  logic              ack_b,
  output logic              timeout,
  output logic [7:0]        err_cnt,
  output logic [15:0]       tx_cnt
);

  localparam int unsigned TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);
  localparam logic [7:0] HOLD_SAT  = 8'(HOLD_MIN);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MIN - 1);

  launch_state_t     state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              en_q, en_d;
  logic              rdy_q, rdy_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        err_q, err_d;
  logic [15:0]       tx_q, tx_d;
  logic [7:0]        hold_q, hold_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              ack_s;

  bit_sync #(
    .N(SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk_a),
    .rstn(arstn),
    .d   (ack_b),
    .q   (ack_s)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    en_d      = en_q;
    rdy_d     = rdy_q;
    timeout_d = 1'b0;
    err_d     = err_q;
    tx_d      = tx_q;
    hold_d    = hold_q;
    to_d      = to_q;
    unique case (state_q)
      StIdle: begin
        rdy_d = 1'b1;
        en_d  = 1'b0;
        if (in_valid && rdy_q) begin
          data_d  = in_data;
          rdy_d   = 1'b0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        en_d    = 1'b1;
        hold_d  = '0;
        to_d    = '0;
        state_d = StAssert;
      end
      StAssert: begin
        if (hold_q != HOLD_SAT) hold_d = hold_q + 8'd1;
        to_d = to_q + 1'b1;
        // Acknowledge takes priority over a timeout qualifying in the same cycle.
        if (ack_s && (hold_q >= HOLD_LAST)) begin
          en_d    = 1'b0;
          tx_d    = tx_q + 16'd1;
          state_d = StRelease;
        end else if ((ACK_TIMEOUT != 0) && (to_q == TO_LAST)) begin
          en_d      = 1'b0;
          timeout_d = 1'b1;
          if (err_q != 8'hff) err_d = err_q + 8'd1;
          state_d   = StRelease;
        end
      end
      StRelease: begin
        if (!ack_s) begin
          rdy_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_a) begin
    if (!arstn) begin
      state_q   <= StIdle;
      data_q    <= '0;
      en_q      <= 1'b0;
      rdy_q     <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      tx_q      <= '0;
      hold_q    <= '0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      en_q      <= en_d;
      rdy_q     <= rdy_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      tx_q      <= tx_d;
      hold_q    <= hold_d;
      to_q      <= to_d;
    end
  end

  assign in_ready = rdy_q;
  assign data_in  = data_q;
  assign data_en  = en_q;
  assign timeout  = timeout_q;
  assign err_cnt  = err_q;
  assign tx_cnt   = tx_q;

endmodule
